// File: rtl/mem_pipe_pkg.sv
// Shared types for the memory pipe: AGU mode encodings, default widths,
// and the queue entry bundle handed to the memory/LSQ stage.
package mem_pipe_pkg;

    localparam int ADDR_W_D   = 16;
    localparam int OFFSET_W_D = 8;
    localparam int PREG_W_D   = 5;
    localparam int DATA_W_D   = 8;
    localparam int ARCH_W_D   = 8;
    localparam int DEPTH_D    = 4;

    typedef enum logic [1:0] {
        MODE_FULL = 2'b00,
        MODE_PAGE = 2'b01,
        MODE_ZP   = 2'b10,
        MODE_RSVD = 2'b11
    } agu_mode_e;

    // Entry layout at the default widths
    typedef struct packed {
        logic [ADDR_W_D-1:0] addr;
        logic                page_cross;
        logic                store;
        logic [PREG_W_D-1:0] dest_preg;
        logic [DATA_W_D-1:0] data;
        logic [ARCH_W_D-1:0] arch_regs;
    } mem_entry_t;

endpackage

// File: rtl/agu_addr_calc.sv
// Effective address generation for the three 6502 addressing modes,
// with page-cross detection on the full-add path.
module agu_addr_calc
    import mem_pipe_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_D,
    parameter int OFFSET_W = OFFSET_W_D
) (
    input  logic [ADDR_W-1:0]   base,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [1:0]          mode,
    output logic [ADDR_W-1:0]   addr,
    output logic                page_cross
);

    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] full_sum;
    logic [7:0]        lo_sum;

    assign off_ext  = ADDR_W'(offset);
    assign full_sum = base + off_ext;
    assign lo_sum   = base[7:0] + off_ext[7:0];

    // Reserved mode falls through to the full-add default
    always_comb begin
        addr       = full_sum;
        page_cross = (full_sum[ADDR_W-1:8] != base[ADDR_W-1:8]);
        unique case (1'b1)
            (mode == MODE_PAGE): begin
                addr       = {base[ADDR_W-1:8], lo_sum};
                page_cross = 1'b0;
            end
            (mode == MODE_ZP): begin
                addr       = {{(ADDR_W-8){1'b0}}, lo_sum};
                page_cross = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_agu_queue.sv
// Memory address stage: AGU at enqueue feeding an in-order FIFO
// toward the memory/LSQ stage, with flush and occupancy.
module mem_agu_queue
    import mem_pipe_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_D,
    parameter int OFFSET_W = OFFSET_W_D,
    parameter int PREG_W   = PREG_W_D,
    parameter int DATA_W   = DATA_W_D,
    parameter int ARCH_W   = ARCH_W_D,
    parameter int DEPTH    = DEPTH_D,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_store,
    input  logic [1:0]          in_mode,
    input  logic [ADDR_W-1:0]   in_base,
    input  logic [OFFSET_W-1:0] in_offset,
    input  logic [PREG_W-1:0]   in_dest_preg,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [ARCH_W-1:0]   in_arch_regs,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_page_cross,
    output logic                out_store,
    output logic [PREG_W-1:0]   out_dest_preg,
    output logic [DATA_W-1:0]   out_data,
    output logic [ARCH_W-1:0]   out_arch_regs,
    output logic [CNT_W-1:0]    occupancy
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              page_cross;
        logic              store;
        logic [PREG_W-1:0] dest_preg;
        logic [DATA_W-1:0] data;
        logic [ARCH_W-1:0] arch_regs;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            new_entry;
    entry_t            head;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] calc_addr;
    logic              calc_pc;
    logic              push;
    logic              pop;

    agu_addr_calc #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) u_calc (
        .base       (in_base),
        .offset     (in_offset),
        .mode       (in_mode),
        .addr       (calc_addr),
        .page_cross (calc_pc)
    );

    assign new_entry = '{
        addr:       calc_addr,
        page_cross: calc_pc,
        store:      in_store,
        dest_preg:  in_dest_preg,
        data:       in_data,
        arch_regs:  in_arch_regs
    };

    // A full queue still accepts when the head leaves in the same cycle
    assign in_ready  = !flush && ((count < CNT_W'(DEPTH)) || out_ready);
    assign out_valid = (count != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    assign head           = mem[rd_ptr];
    assign out_addr       = head.addr;
    assign out_page_cross = head.page_cross;
    assign out_store      = head.store;
    assign out_dest_preg  = head.dest_preg;
    assign out_data       = head.data;
    assign out_arch_regs  = head.arch_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_agu_queue.md
Name: mem_agu_queue

Overview:
- Parametrised successor of the single-entry memory address stage in the OoO 6502 memory path.
- Accepts load/store micro-ops from issue and computes the effective address under one of three 6502 addressing modes.
- Flags page crossings and buffers results in a DEPTH-entry in-order FIFO ahead of the memory/LSQ stage.
- Adds flush (mispredict squash) and occupancy reporting.

Parameters:
- ADDR_W, 16, address width; must be >= 9.
- OFFSET_W, 8, index/offset width; unsigned, zero-extended; must be <= ADDR_W.
- PREG_W, 5, physical destination register tag width.
- DATA_W, 8, store data width.
- ARCH_W, 8, architectural-register one-hot mask width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  squash all buffered and incoming entries
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept this cycle
- in_store  in  1  1=store, 0=load
- in_mode  in  2  00 full add, 01 page wrap, 10 zero page, 11 reserved (treated as 00)
- in_base  in  ADDR_W  base address
- in_offset  in  OFFSET_W  index/offset
- in_dest_preg  in  PREG_W  destination physical reg (loads)
- in_data  in  DATA_W  store data
- in_arch_regs  in  ARCH_W  architectural dest mask
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_addr  out  ADDR_W  effective address
- out_page_cross  out  1  full-add result crossed a 256-byte page
- out_store, out_dest_preg, out_data, out_arch_regs  out  1/PREG_W/DATA_W/ARCH_W  carried fields
- occupancy  out  clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst_n low, async):
  - count, rd_ptr and wr_ptr cleared to 0; all storage entries zeroed.
  - out_valid=0, in_ready=1, occupancy=0; all data outputs read as 0.
- Address arithmetic (combinational at enqueue, stored in the entry):
  - Mode 00/11: addr = (base + zext(offset)) mod 2^ADDR_W; page_cross = (addr[ADDR_W-1:8] != base[ADDR_W-1:8]).
  - Mode 01: addr = {base[ADDR_W-1:8], (base[7:0]+offset[7:0]) mod 256}; page_cross=0.
  - Mode 10: addr = {0, (base[7:0]+offset[7:0]) mod 256}; page_cross=0.
  - Mode 10 ignores base upper bits and offset bits above bit 7.
- Handshake:
  - in_ready = !flush & ((count < DEPTH) | out_ready).
  - Enqueue when in_valid & in_ready.
  - Dequeue when out_valid & out_ready.
  - out_valid = (count != 0) & !flush.
  - Outputs read the head entry directly from storage (no extra register).
- Latency: an op enqueued at edge N is visible at out_* after N (1 cycle) if the FIFO was empty. Each queued entry ahead of it adds one accepted dequeue.
- Throughput: 1 op/cycle sustained.
- Full:
  - Simultaneous enqueue+dequeue is allowed; count is unchanged, both pointers advance.
  - With no dequeue, in_ready=0.
- Empty: out_valid=0; enqueue and dequeue in the same cycle cannot occur (no bypass).
- Pointers wrap modulo DEPTH.
- Flush (synchronous, highest priority):
  - At the next edge, count=0 and rd_ptr=wr_ptr=0.
  - The same-cycle input is dropped, and no dequeue occurs in that cycle.
- Ordering: strictly FIFO; fields of an entry never change after enqueue.
- Reset asserted mid-stream discards all entries immediately (asynchronously).

Decomposition:
- Shared package mem_pipe_pkg:
  - MODE_FULL=2'b00, MODE_PAGE=2'b01, MODE_ZP=2'b10, MODE_RSVD=2'b11.
  - Entry struct typedef {addr, page_cross, store, dest_preg, data, arch_regs}.
- Sub-module agu_addr_calc: combinational (base, offset, mode) -> (addr, page_cross), parametrised by ADDR_W and OFFSET_W.
- FIFO control stays in the top module.

Test Plan:
- Reset then single op: mode 00, base 0x12F0, offset 0x20, out_ready=1. Required: one cycle later out_valid=1, out_addr=0x1310, out_page_cross=1; following cycle out_valid=0.
- Mode 01, base 0x12F0, offset 0x20 -> out_addr=0x1210, page_cross=0. Mode 10, base 0xABFF, offset 0x02 -> out_addr=0x0001, page_cross=0.
- out_ready=0, push 5 ops (DEPTH=4): 4 accepted, in_ready=0 on the 5th, occupancy=4. Then out_ready=1: outputs appear in order; push and pop in the same cycle while full keeps occupancy=4.
- Store op: in_store=1, in_data=0x5A, arch mask 0x04 -> out_store=1, out_data=0x5A, out_arch_regs=0x04, unchanged while stalled 3 cycles.
- 3 entries queued, assert flush for 1 cycle with in_valid=1. Required: in_ready=0 and out_valid=0 during flush; next cycle occupancy=0; the dropped input never appears.
- Assert rst_n low asynchronously mid-stream with 2 entries: out_valid=0 and occupancy=0 before the next clock edge.
